// File: rtl/mul_err_eval_ctrl.sv
// ---------------------------------------------------------------------------
// mul_err_eval_ctrl
//
// Sequencer and scorer for one approximate multiplier under error evaluation.
// It steps through every input vector of the external multiplier in order and
// holds each vector on dut_a for HOLD cycles. On the last hold cycle it
// compares the returned product dut_y with the exact product a*b. Across the
// run it accumulates the error count, the worst-case error distance and the
// summed error distance.
//
// Optional feature macro: ERR_EVAL_WCE_VEC_EN
//   When defined, adds the wce_vec output. wce_vec records the vector that
//   first produced the current max_ed.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a run; only sampled in IDLE
//   busy       out  run in progress (one or more cycles per vector)
//   done       out  one-cycle pulse once the results are final
//   dut_a      out  vector to the multiplier; a = low half, b = high half
//   dut_y      in   multiplier output, zero-extended to IN_W for the compare
//   err_cnt    out  number of vectors with approx != exact
//   max_ed     out  maximum |exact - approx|
//   sum_ed     out  sum of |exact - approx|
//   wce_vec    out  (ERR_EVAL_WCE_VEC_EN only) vector that gave max_ed
//   dbg_state  out  current FSM state encoding (IDLE=0, RUN=1, DONE=2)
//
// Handshake: the host raises start while busy=0. The run begins on the next
// edge. busy stays high for HOLD*2^IN_W cycles, and done pulses for the one
// cycle after busy falls. The results stay stable from done until the next
// accepted start. Any start seen while a run or the DONE cycle is in
// progress is dropped and not queued.
// ---------------------------------------------------------------------------
module mul_err_eval_ctrl #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4,
  parameter int HOLD  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IN_W-1:0]     dut_a,
  input  logic [OUT_W-1:0]    dut_y,
  output logic [IN_W:0]       err_cnt,
  output logic [IN_W-1:0]     max_ed,
  output logic [2*IN_W-1:0]   sum_ed,
`ifdef ERR_EVAL_WCE_VEC_EN
  output logic [IN_W-1:0]     wce_vec,
`endif
  output logic [1:0]          dbg_state
);

  localparam int HALF  = IN_W / 2;
  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IN_W-1:0]     dut_a_q, dut_a_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_W:0]       err_q, err_d;
  logic [IN_W-1:0]     max_q, max_d;
  logic [2*IN_W-1:0]   sum_q, sum_d;
`ifdef ERR_EVAL_WCE_VEC_EN
  logic [IN_W-1:0]     wce_q, wce_d;
`endif

  // Exact product. Each operand is HALF bits wide, so the product always
  // fits in IN_W bits.
  logic [IN_W-1:0] op_a, op_b, exact, approx, ed;

  assign op_a   = IN_W'(dut_a_q[HALF-1:0]);
  assign op_b   = IN_W'(dut_a_q[IN_W-1:HALF]);
  assign exact  = op_a * op_b;
  assign approx = IN_W'(dut_y);
  assign ed     = (exact >= approx) ? (exact - approx) : (approx - exact);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dut_a_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
`ifdef ERR_EVAL_WCE_VEC_EN
      wce_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dut_a_q <= dut_a_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
`ifdef ERR_EVAL_WCE_VEC_EN
      wce_q   <= wce_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    dut_a_d = dut_a_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    max_d   = max_q;
    sum_d   = sum_q;
`ifdef ERR_EVAL_WCE_VEC_EN
    wce_d   = wce_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          dut_a_d = '0;
          cnt_d   = '0;
          err_d   = '0;
          max_d   = '0;
          sum_d   = '0;
`ifdef ERR_EVAL_WCE_VEC_EN
          wce_d   = '0;
`endif
        end
      end

      S_RUN: begin
        if (cnt_q == HOLD_LAST) begin
          // dut_y has now settled for the vector held on dut_a, so score it.
          cnt_d = '0;
          err_d = err_q + (IN_W+1)'(ed != '0);
          sum_d = sum_q + (2*IN_W)'(ed);
          // A strict compare keeps the first vector that reaches the maximum.
          if (ed > max_q) begin
            max_d = ed;
`ifdef ERR_EVAL_WCE_VEC_EN
            wce_d = dut_a_q;
`endif
          end
          if (dut_a_q == '1) begin
            state_d = S_DONE;
            dut_a_d = '0;
          end else begin
            dut_a_d = dut_a_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        dut_a_d = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign dut_a     = dut_a_q;
  assign err_cnt   = err_q;
  assign max_ed    = max_q;
  assign sum_ed    = sum_q;
`ifdef ERR_EVAL_WCE_VEC_EN
  assign wce_vec   = wce_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_err_eval_ctrl.sv
// Testbench for mul_err_eval_ctrl (IN_W=4, OUT_W=4).
// u_dut1: HOLD=1, driven by a combinational lookup-table multiplier stub.
// u_dut3: HOLD=3, driven by a registered lookup-table stub with latency 1.
// Expected results come from a loop over all 16 vectors using plain
// arithmetic.
module tb_mul_err_eval_ctrl;
  localparam int IN_W  = 4;
  localparam int OUT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start1, start3;
  logic busy1, done1, busy3, done3;
  logic [IN_W-1:0]   dut_a1, dut_a3;
  logic [OUT_W-1:0]  y1, y3;
  logic [IN_W:0]     err1, err3;
  logic [IN_W-1:0]   max1, max3;
  logic [2*IN_W-1:0] sum1, sum3;
`ifdef ERR_EVAL_WCE_VEC_EN
  logic [IN_W-1:0]   wce1, wce3;
`endif
  logic [1:0]        st1, st3;

  logic [OUT_W-1:0] lut1 [16];
  logic [OUT_W-1:0] lut3 [16];

  assign y1 = lut1[dut_a1];
  always @(posedge clk) y3 <= lut3[dut_a3];

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mul_err_eval_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .dut_a(dut_a1), .dut_y(y1), .err_cnt(err1), .max_ed(max1), .sum_ed(sum1),
`ifdef ERR_EVAL_WCE_VEC_EN
    .wce_vec(wce1),
`endif
    .dbg_state(st1)
  );

  mul_err_eval_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .HOLD(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .dut_a(dut_a3), .dut_y(y3), .err_cnt(err3), .max_ed(max3), .sum_ed(sum3),
`ifdef ERR_EVAL_WCE_VEC_EN
    .wce_vec(wce3),
`endif
    .dbg_state(st3)
  );

  // Reference model: pushes err, max, sum, wce for the chosen stub table.
  task automatic model_push(input int sel);
    int e, m, s, w;
    e = 0; m = 0; s = 0; w = 0;
    for (int v = 0; v < 16; v++) begin
      int a, b, ap, ed;
      a  = v % 4;
      b  = v / 4;
      ap = (sel == 1) ? int'(lut1[v]) : int'(lut3[v]);
      ed = a * b - ap;
      if (ed < 0) ed = -ed;
      if (ed != 0) e++;
      s += ed;
      if (ed > m) begin m = ed; w = v; end
    end
    exp_q.push_back(32'(e));
    exp_q.push_back(32'(m));
    exp_q.push_back(32'(s));
    exp_q.push_back(32'(w));
  endtask

  task automatic fill_lut(input int sel, input int kind);
    for (int v = 0; v < 16; v++) begin
      logic [OUT_W-1:0] val;
      case (kind)
        0:       val = OUT_W'((v % 4) * (v / 4));
        1:       val = '0;
        2:       val = '1;
        default: val = OUT_W'($urandom_range(0, 15));
      endcase
      if (sel == 1) lut1[v] = val; else lut3[v] = val;
    end
  endtask

  // Pulses start for one cycle, then counts busy cycles until done. A second
  // sample after done catches a done pulse that lasts too long.
  task automatic run_inst(input int sel, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    @(posedge clk); #1;
    if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if ((sel == 1) ? busy1 : busy3) busy_n++;
      if ((sel == 1) ? done1 : done3) begin done_n++; break; end
    end
    @(negedge clk);
    if ((sel == 1) ? done1 : done3) done_n++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done1); end
    total++; if (dut_a1 !== 4'h0) begin bad++; $display("FAIL reset_dut_a: got %h want 0", dut_a1); end
    total++; if (err1 !== 5'd0 || max1 !== 4'd0 || sum1 !== 8'd0) begin
      bad++; $display("FAIL reset_results: got err=%0d max=%0d sum=%0d want 0/0/0", err1, max1, sum1);
    end
    total++; if (busy3 !== 1'b0 || done3 !== 1'b0 || st3 !== 2'd0) begin
      bad++; $display("FAIL reset_inst3: got busy=%b done=%b st=%0d want 0/0/0", busy3, done3, st3);
    end
`ifdef ERR_EVAL_WCE_VEC_EN
    total++; if (wce1 !== 4'h0) begin bad++; $display("FAIL reset_wce: got %h want 0", wce1); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // kind: 0 exact, 1 all zero, 2 all ones, 3 random table.
  task automatic test_pattern(input int kind);
    int bn, dn;
    logic [31:0] e, m, s, w;
    fill_lut(1, kind);
    model_push(1);
    run_inst(1, bn, dn);
    e = exp_q.pop_front(); m = exp_q.pop_front(); s = exp_q.pop_front(); w = exp_q.pop_front();
    total++; if (bn != 16) begin bad++; $display("FAIL pat%0d_busy_len: got %0d want 16", kind, bn); end
    total++; if (dn != 1) begin bad++; $display("FAIL pat%0d_done_pulse: got %0d want 1", kind, dn); end
    total++; if (err1 !== 5'(e)) begin bad++; $display("FAIL pat%0d_err_cnt: got %0d want %0d", kind, err1, e); end
    total++; if (max1 !== 4'(m)) begin bad++; $display("FAIL pat%0d_max_ed: got %0d want %0d", kind, max1, m); end
    total++; if (sum1 !== 8'(s)) begin bad++; $display("FAIL pat%0d_sum_ed: got %0d want %0d", kind, sum1, s); end
`ifdef ERR_EVAL_WCE_VEC_EN
    total++; if (wce1 !== 4'(w)) begin bad++; $display("FAIL pat%0d_wce_vec: got %h want %h", kind, wce1, w); end
`endif
    // The results must hold while the block sits idle.
    repeat (3) @(negedge clk);
    total++; if (err1 !== 5'(e) || sum1 !== 8'(s)) begin
      bad++; $display("FAIL pat%0d_hold: got err=%0d sum=%0d want %0d/%0d", kind, err1, sum1, e, s);
    end
  endtask

  task automatic test_hold3(input int kind);
    int bn, dn, seq_bad;
    logic [31:0] e, m, s, w;
    fill_lut(3, kind);
    model_push(3);
    bn = 0; dn = 0; seq_bad = 0;
    @(posedge clk); #1; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy3) begin
        if (int'(dut_a3) != bn / 3) seq_bad++;
        bn++;
      end
      if (done3) begin dn++; break; end
    end
    e = exp_q.pop_front(); m = exp_q.pop_front(); s = exp_q.pop_front(); w = exp_q.pop_front();
    total++; if (bn != 48) begin bad++; $display("FAIL hold3_busy_len: got %0d want 48", bn); end
    total++; if (dn != 1) begin bad++; $display("FAIL hold3_done: got %0d want 1", dn); end
    total++; if (seq_bad != 0) begin bad++; $display("FAIL hold3_dut_a_seq: got %0d bad samples want 0", seq_bad); end
    total++; if (err3 !== 5'(e) || max3 !== 4'(m) || sum3 !== 8'(s)) begin
      bad++; $display("FAIL hold3_results: got %0d/%0d/%0d want %0d/%0d/%0d", err3, max3, sum3, e, m, s);
    end
`ifdef ERR_EVAL_WCE_VEC_EN
    total++; if (wce3 !== 4'(w)) begin bad++; $display("FAIL hold3_wce_vec: got %h want %h", wce3, w); end
`endif
  endtask

  task automatic test_reset_mid_run();
    int bn, dn;
    fill_lut(1, 2);
    bn = 0; dn = 0;
    @(posedge clk); #1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    for (int c = 0; c < 50 && bn < 7; c++) begin
      @(negedge clk);
      if (busy1) bn++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bn != 7) begin bad++; $display("FAIL midrst_reach: got %0d want 7", bn); end
    total++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++; $display("FAIL midrst_flags: got busy=%b done=%b want 0/0", busy1, done1);
    end
    total++; if (err1 !== 5'd0 || max1 !== 4'd0 || sum1 !== 8'd0 || dut_a1 !== 4'h0) begin
      bad++; $display("FAIL midrst_results: got %0d/%0d/%0d a=%h want 0", err1, max1, sum1, dut_a1);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done1 || busy1) dn++;
    end
    total++; if (dn != 0) begin bad++; $display("FAIL midrst_no_done: got %0d active cycles want 0", dn); end
  endtask

  task automatic test_start_ignored();
    int bn, dn, late;
    logic [31:0] e, m, s, w;
    fill_lut(1, 3);
    model_push(1);
    bn = 0; dn = 0; late = 0;
    @(posedge clk); #1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy1) bn++;
      start1 = (bn == 5 || bn == 11) ? 1'b1 : 1'b0;
      if (done1) begin dn++; start1 = 1'b1; break; end
    end
    // start was high at the edge that leaves DONE; it must be dropped.
    @(negedge clk); start1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy1) late++;
    end
    e = exp_q.pop_front(); m = exp_q.pop_front(); s = exp_q.pop_front(); w = exp_q.pop_front();
    total++; if (bn != 16 || dn != 1) begin bad++; $display("FAIL ignore_timing: got busy=%0d done=%0d want 16/1", bn, dn); end
    total++; if (err1 !== 5'(e) || max1 !== 4'(m) || sum1 !== 8'(s)) begin
      bad++; $display("FAIL ignore_results: got %0d/%0d/%0d want %0d/%0d/%0d", err1, max1, sum1, e, m, s);
    end
    total++; if (late != 0) begin bad++; $display("FAIL ignore_done_start: got %0d busy cycles want 0", late); end
  endtask

  task automatic test_back_to_back();
    int bn, dn;
    logic [31:0] e, m, s, w;
    fill_lut(1, 2);
    model_push(1);
    bn = 0; dn = 0;
    @(posedge clk); #1; start1 = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done1) begin dn++; break; end
    end
    @(negedge clk);
    total++; if (busy1 !== 1'b0 || st1 !== 2'd0) begin
      bad++; $display("FAIL b2b_idle_gap: got busy=%b st=%0d want 0/0", busy1, st1);
    end
    @(negedge clk);
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b want 1", busy1); end
    total++; if (err1 !== 5'd0 || max1 !== 4'd0 || sum1 !== 8'd0) begin
      bad++; $display("FAIL b2b_cleared: got %0d/%0d/%0d want 0/0/0", err1, max1, sum1);
    end
    start1 = 1'b0;
    bn = busy1 ? 1 : 0;
    dn = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy1) bn++;
      if (done1) begin dn++; break; end
    end
    e = exp_q.pop_front(); m = exp_q.pop_front(); s = exp_q.pop_front(); w = exp_q.pop_front();
    total++; if (bn != 16 || dn != 1) begin bad++; $display("FAIL b2b_timing: got busy=%0d done=%0d want 16/1", bn, dn); end
    total++; if (err1 !== 5'(e) || max1 !== 4'(m) || sum1 !== 8'(s)) begin
      bad++; $display("FAIL b2b_results: got %0d/%0d/%0d want %0d/%0d/%0d", err1, max1, sum1, e, m, s);
    end
  endtask

  initial begin
    for (int v = 0; v < 16; v++) begin lut1[v] = '0; lut3[v] = '0; end
    test_reset();
    test_pattern(0);
    test_pattern(1);
    test_pattern(2);
    for (int i = 0; i < 4; i++) test_pattern(3);
    test_hold3(1);
    test_hold3(3);
    test_reset_mid_run();
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
